// File: rtl/muldiv_sequencer.sv
// Sequences the shared multi-cycle MULT/DIV units for the multicycle CPU and commits
// their results into the architectural HI/LO registers after the fixed unit latency.
module muldiv_sequencer #(
    parameter int MULT_LATENCY = 33,
    parameter int DIV_LATENCY  = 33,
    parameter int CNT_W        = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        op_ready,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic        mult_start,
    output logic        div_start,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int DATA_W = 32;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LATENCY);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MULT_WAIT = 2'd1,
        S_DIV_WAIT  = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [CNT_W-1:0]           r_cnt;
    logic signed [DATA_W-1:0]   r_hi;
    logic signed [DATA_W-1:0]   r_lo;
    logic signed [DATA_W-1:0]   r_unit_a;
    logic signed [DATA_W-1:0]   r_unit_b;
    logic                       r_mult_start;
    logic                       r_div_start;
    logic                       r_done;
    logic                       r_div_zero;

    logic                       w_busy;
    logic                       w_idle_op;
    logic                       w_mult_go;
    logic                       w_div_go;
    logic                       w_div_zero;
    logic                       w_mthi;
    logic                       w_mtlo;
    logic                       w_commit;
    logic signed [DATA_W-1:0]   w_res_hi;
    logic signed [DATA_W-1:0]   w_res_lo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (op_valid && op == OP_MULT) begin
                    w_state_nxt = S_MULT_WAIT;
                end else if (op_valid && op == OP_DIV && rt_val != '0) begin
                    w_state_nxt = S_DIV_WAIT;
                end
            end
            S_MULT_WAIT, S_DIV_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Ops are only taken in IDLE; anything presented while busy is dropped, not queued.
    always_comb begin
        w_busy     = (r_state != S_IDLE);
        w_idle_op  = !w_busy && op_valid;
        w_mult_go  = w_idle_op && (op == OP_MULT);
        w_div_go   = w_idle_op && (op == OP_DIV) && (rt_val != '0);
        w_div_zero = w_idle_op && (op == OP_DIV) && (rt_val == '0);
        w_mthi     = w_idle_op && (op == OP_MTHI);
        w_mtlo     = w_idle_op && (op == OP_MTLO);
        w_commit   = w_busy && (r_cnt == '0);
        w_res_hi   = (r_state == S_DIV_WAIT) ? $signed(div_hi) : $signed(mult_hi);
        w_res_lo   = (r_state == S_DIV_WAIT) ? $signed(div_lo) : $signed(mult_lo);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_unit_a     <= '0;
            r_unit_b     <= '0;
            r_mult_start <= 1'b0;
            r_div_start  <= 1'b0;
            r_done       <= 1'b0;
            r_div_zero   <= 1'b0;
        end else begin
            r_mult_start <= w_mult_go;
            r_div_start  <= w_div_go;
            r_div_zero   <= w_div_zero;
            r_done       <= w_commit;

            if (w_mult_go || w_div_go) begin
                r_unit_a <= $signed(rs_val);
                r_unit_b <= $signed(rt_val);
            end

            // The counter reaches zero one edge before commit, giving LATENCY+1 edges total.
            if (w_mult_go) begin
                r_cnt <= MULT_CNT;
            end else if (w_div_go) begin
                r_cnt <= DIV_CNT;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (w_commit) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else begin
                if (w_mthi) begin
                    r_hi <= $signed(rs_val);
                end
                if (w_mtlo) begin
                    r_lo <= $signed(rs_val);
                end
            end
        end
    end

    assign busy       = w_busy;
    assign op_ready   = !w_busy;
    assign done       = r_done;
    assign div_zero   = r_div_zero;
    assign mult_start = r_mult_start;
    assign div_start  = r_div_start;
    assign unit_a     = r_unit_a;
    assign unit_b     = r_unit_b;
    assign hi         = r_hi;
    assign lo         = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: behavioural MULT/DIV unit models with a
// fixed latency, a result scoreboard, a vector table and hand-written corner sequences.
module tb_muldiv_sequencer;

    localparam int LAT = 33;
    localparam int NV  = 9;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        op_ready;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        mult_start;
    logic        div_start;
    logic [31:0] unit_a;
    logic [31:0] unit_b;
    logic [31:0] mult_hi = '0;
    logic [31:0] mult_lo = '0;
    logic [31:0] div_hi  = '0;
    logic [31:0] div_lo  = '0;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;
    int n_ms   = 0;
    int n_ds   = 0;
    int n_done = 0;
    int m_cnt  = 0;

    logic [63:0] sb[$];
    logic [63:0] sb_e;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        dz;
    } vec_t;

    vec_t tbl[NV];

    muldiv_sequencer #(
        .MULT_LATENCY(33),
        .DIV_LATENCY (33),
        .CNT_W       (7)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .op_ready  (op_ready),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .mult_start(mult_start),
        .div_start (div_start),
        .unit_a    (unit_a),
        .unit_b    (unit_b),
        .mult_hi   (mult_hi),
        .mult_lo   (mult_lo),
        .div_hi    (div_hi),
        .div_lo    (div_lo),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    // Unit models: outputs are garbage until LAT edges after the start pulse is sampled.
    logic signed [63:0] w_prod;
    logic signed [31:0] w_quo;
    logic signed [31:0] w_rem;
    assign w_prod = $signed(unit_a) * $signed(unit_b);
    assign w_quo  = (unit_b == '0) ? 32'sd0 : $signed(unit_a) / $signed(unit_b);
    assign w_rem  = (unit_b == '0) ? 32'sd0 : $signed(unit_a) % $signed(unit_b);

    always @(posedge clk) begin
        if (mult_start || div_start) begin
            m_cnt   <= LAT - 1;
            mult_hi <= 32'hA5A5A5A5;
            mult_lo <= 32'h5A5A5A5A;
            div_hi  <= 32'hC3C3C3C3;
            div_lo  <= 32'h3C3C3C3C;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                mult_hi <= w_prod[63:32];
                mult_lo <= w_prod[31:0];
                div_hi  <= w_rem;
                div_lo  <= w_quo;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mult_start) n_ms++;
        if (div_start)  n_ds++;
        if (done)       n_done++;
        if (!reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_done: got done=1 with hi=%h lo=%h, expected no commit", hi, lo);
            end else begin
                sb_e = sb.pop_front();
                chk("sb_hi", hi, sb_e[63:32]);
                chk("sb_lo", lo, sb_e[31:0]);
            end
        end
    end

    // Drive an op at a negedge; it is sampled at the following posedge (E0).
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        op       = o;
        rs_val   = a;
        rt_val   = b;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 60);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done after %0d cycles, expected done", name, lat);
        end
    endtask

    initial begin
        int lat;
        int ms0;
        int ds0;
        int nd0;
        logic long_op;

        tbl[0] = '{op: OP_MULT, rs: 32'd7,        rt: 32'hFFFFFFFD, ehi: 32'hFFFFFFFF, elo: 32'hFFFFFFEB, dz: 1'b0};
        tbl[1] = '{op: OP_DIV,  rs: 32'd100,      rt: 32'd7,        ehi: 32'd2,        elo: 32'd14,       dz: 1'b0};
        tbl[2] = '{op: OP_DIV,  rs: 32'd5,        rt: 32'd0,        ehi: 32'd2,        elo: 32'd14,       dz: 1'b1};
        tbl[3] = '{op: OP_MULT, rs: 32'hFFFFFFFB, rt: 32'hFFFFFFFA, ehi: 32'h0,        elo: 32'h1E,       dz: 1'b0};
        tbl[4] = '{op: OP_DIV,  rs: 32'hFFFFFF9C, rt: 32'd7,        ehi: 32'hFFFFFFFE, elo: 32'hFFFFFFF2, dz: 1'b0};
        tbl[5] = '{op: OP_MTHI, rs: 32'hDEADBEEF, rt: 32'd0,        ehi: 32'hDEADBEEF, elo: 32'hFFFFFFF2, dz: 1'b0};
        tbl[6] = '{op: OP_MTLO, rs: 32'h0BADF00D, rt: 32'd9,        ehi: 32'hDEADBEEF, elo: 32'h0BADF00D, dz: 1'b0};
        tbl[7] = '{op: OP_MULT, rs: 32'h7FFFFFFF, rt: 32'h7FFFFFFF, ehi: 32'h3FFFFFFF, elo: 32'h00000001, dz: 1'b0};
        tbl[8] = '{op: OP_MULT, rs: 32'h80000000, rt: 32'd2,        ehi: 32'hFFFFFFFF, elo: 32'h00000000, dz: 1'b0};

        reset    = 1'b1;
        op_valid = 1'b0;
        op       = 2'b00;
        rs_val   = '0;
        rt_val   = '0;
        repeat (2) @(negedge clk);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_op_ready", 32'(op_ready), 32'd1);
        chk("rst_pulses", {28'd0, mult_start, div_start, done, div_zero}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            ms0 = n_ms;
            ds0 = n_ds;
            long_op = (tbl[i].op == OP_MULT) || (tbl[i].op == OP_DIV && !tbl[i].dz);
            if (long_op) sb.push_back({tbl[i].ehi, tbl[i].elo});
            issue(tbl[i].op, tbl[i].rs, tbl[i].rt);
            if (long_op) begin
                chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
                chk($sformatf("v%0d_op_ready", i), 32'(op_ready), 32'd0);
                chk($sformatf("v%0d_unit_a", i), unit_a, tbl[i].rs);
                chk($sformatf("v%0d_unit_b", i), unit_b, tbl[i].rt);
                wait_done($sformatf("v%0d", i), lat);
                chk($sformatf("v%0d_latency", i), 32'(lat), 32'd34);
                chk($sformatf("v%0d_busy_end", i), 32'(busy), 32'd0);
            end else begin
                chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
                chk($sformatf("v%0d_op_ready", i), 32'(op_ready), 32'd1);
                chk($sformatf("v%0d_div_zero", i), 32'(div_zero), 32'(tbl[i].dz));
                @(negedge clk);
                chk($sformatf("v%0d_div_zero_end", i), 32'(div_zero), 32'd0);
            end
            chk($sformatf("v%0d_hi", i), hi, tbl[i].ehi);
            chk($sformatf("v%0d_lo", i), lo, tbl[i].elo);
            chk($sformatf("v%0d_mult_pulses", i), 32'(n_ms - ms0), 32'(tbl[i].op == OP_MULT));
            chk($sformatf("v%0d_div_pulses", i), 32'(n_ds - ds0),
                32'(tbl[i].op == OP_DIV && !tbl[i].dz));
        end

        // MTHI presented mid-MULT must be dropped.
        sb.push_back({32'h0, 32'hF});
        issue(OP_MULT, 32'd3, 32'd5);
        repeat (9) @(negedge clk);
        op_valid = 1'b1;
        op       = OP_MTHI;
        rs_val   = 32'h1234;
        chk("ign_op_ready", 32'(op_ready), 32'd0);
        @(negedge clk);
        op_valid = 1'b0;
        chk("ign_hi_mid", hi, 32'hFFFFFFFF);
        wait_done("ign", lat);
        chk("ign_hi_end", hi, 32'h0);
        chk("ign_lo_end", lo, 32'hF);
        @(negedge clk);

        // Back-to-back MTHI/MTLO.
        op_valid = 1'b1;
        op       = OP_MTHI;
        rs_val   = 32'hDEADBEEF;
        @(negedge clk);
        chk("mt_hi1", hi, 32'hDEADBEEF);
        chk("mt_lo1", lo, 32'hF);
        chk("mt_busy1", 32'(busy), 32'd0);
        op     = OP_MTLO;
        rs_val = 32'h0BADF00D;
        @(negedge clk);
        op_valid = 1'b0;
        chk("mt_hi2", hi, 32'hDEADBEEF);
        chk("mt_lo2", lo, 32'h0BADF00D);
        chk("mt_busy2", 32'(busy), 32'd0);

        // Reset mid-MULT abandons the op.
        issue(OP_MULT, 32'h11, 32'd3);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("arst_hi", hi, 32'h0);
        chk("arst_lo", lo, 32'h0);
        chk("arst_unit_a", unit_a, 32'h0);
        chk("arst_unit_b", unit_b, 32'h0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_op_ready", 32'(op_ready), 32'd1);
        chk("arst_pulses", {28'd0, mult_start, div_start, done, div_zero}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        nd0 = n_done;
        repeat (40) @(negedge clk);
        chk("arst_no_done", 32'(n_done - nd0), 32'd0);
        chk("arst_hi_held", hi, 32'h0);

        sb.push_back({32'h0, 32'h33});
        issue(OP_MULT, 32'h11, 32'd3);
        wait_done("post_rst", lat);
        chk("post_rst_latency", 32'(lat), 32'd34);
        chk("post_rst_lo", lo, 32'h33);
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
